// File: rtl/cpu_pkg.sv
// Shared pipeline constants: IF->ID bus layout and architectural fetch values.
package cpu_pkg;

    localparam int unsigned FS_TO_DS_BUS_WD = 65;

    localparam int unsigned ADEF_BIT = 64;
    localparam int unsigned PC_MSB   = 63;
    localparam int unsigned PC_LSB   = 32;
    localparam int unsigned INST_MSB = 31;
    localparam int unsigned INST_LSB = 0;

    localparam logic [31:0] NOP_INST = 32'h03400000;
    localparam logic [31:0] RESET_PC = 32'h1c000000;

    typedef logic [FS_TO_DS_BUS_WD-1:0] fs_bus_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order synchronous FIFO holding fetched IF->ID bus entries.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = FS_TO_DS_BUS_WD,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: dout is forced to zero while the queue is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: queues pre-IF PC/inst pairs, tags ADEF, handles kill and stall.
module if_stage
    import cpu_pkg::*;
#(
    parameter int unsigned QDEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pfs_to_fs_valid,
    input  logic [31:0]                pfs_pc,
    input  logic [31:0]                inst_sram_rdata,
    input  logic                       br_taken_cancel,
    input  logic                       flush,
    input  logic                       ds_allowin,
    output logic                       fs_stall,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

    logic             kill;
    logic             push;
    logic             pop;
    logic             pc_adef;
    logic             exc_lock_q, exc_lock_d;
    logic [CNT_W-1:0] count;
    fs_bus_t          push_bus;
    fs_bus_t          head_bus;

    always_comb begin
        kill           = flush | br_taken_cancel;
        fs_stall       = (count == CNT_W'(QDEPTH)) | exc_lock_q;
        push           = pfs_to_fs_valid & ~fs_stall & ~kill;
        fs_to_ds_valid = (count != '0) & ~kill;
        pop            = fs_to_ds_valid & ds_allowin;

        pc_adef                      = (pfs_pc[1:0] != 2'b00);
        push_bus                     = '0;
        push_bus[ADEF_BIT]           = pc_adef;
        push_bus[PC_MSB:PC_LSB]      = pfs_pc;
        push_bus[INST_MSB:INST_LSB]  = pc_adef ? NOP_INST : inst_sram_rdata;

        // A faulting fetch freezes pre-IF until the exception flush arrives.
        exc_lock_d = exc_lock_q;
        if (flush) begin
            exc_lock_d = 1'b0;
        end else if (push & pc_adef) begin
            exc_lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            exc_lock_q <= 1'b0;
        end else begin
            exc_lock_q <= exc_lock_d;
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (FS_TO_DS_BUS_WD)
    ) u_fetch_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (kill),
        .din   (push_bus),
        .dout  (head_bus),
        .count (count)
    );

    assign fs_to_ds_bus = head_bus;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, then random traffic against a queue model.
module tb_if_stage;
    import cpu_pkg::*;

    localparam int unsigned QDEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        pfs_to_fs_valid;
    logic [31:0] pfs_pc;
    logic [31:0] inst_sram_rdata;
    logic        br_taken_cancel;
    logic        flush;
    logic        ds_allowin;
    logic        fs_stall;
    logic        fs_to_ds_valid;
    fs_bus_t     fs_to_ds_bus;

    always #5 clk = ~clk;

    if_stage #(.QDEPTH(QDEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .pfs_to_fs_valid (pfs_to_fs_valid),
        .pfs_pc          (pfs_pc),
        .inst_sram_rdata (inst_sram_rdata),
        .br_taken_cancel (br_taken_cancel),
        .flush           (flush),
        .ds_allowin      (ds_allowin),
        .fs_stall        (fs_stall),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [31:0] pc;
        logic        cancel;
        logic        flsh;
        logic        allow;
        logic        exp_stall;
        logic        exp_valid;
        fs_bus_t     exp_bus;
    } vec_t;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    vec_t        tbl[20];
    fs_bus_t     model_q[$];
    logic        model_lock;

    // Directed rows use rdata = ~pc so every instruction word is distinct.
    function automatic fs_bus_t ent(input logic [31:0] pc);
        logic adef;
        adef = (pc[1:0] != 2'b00);
        return {adef, pc, adef ? NOP_INST : ~pc};
    endfunction

    task automatic check(input string name, input fs_bus_t act, input fs_bus_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic v, input logic [31:0] pc,
                         input logic [31:0] rdata, input logic cancel,
                         input logic flsh, input logic allow);
        @(negedge clk);
        reset           = rst;
        pfs_to_fs_valid = v;
        pfs_pc          = pc;
        inst_sram_rdata = rdata;
        br_taken_cancel = cancel;
        flush           = flsh;
        ds_allowin      = allow;
        #1;
    endtask

    initial begin
        fs_bus_t     z;
        logic [31:0] pc_cur;
        logic [31:0] rdata;
        logic        rst, v, cancel, flsh, allow;
        logic        e_stall, e_valid, adef;
        fs_bus_t     e_bus;

        z = '0;
        // streaming, then backpressure holding 1c000008
        tbl[0]  = '{1'b0, 1'b1, 32'h1c000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z};
        tbl[1]  = '{1'b0, 1'b1, 32'h1c000004, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ent(32'h1c000000)};
        tbl[2]  = '{1'b0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ent(32'h1c000000)};
        tbl[3]  = '{1'b0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ent(32'h1c000000)};
        tbl[4]  = '{1'b0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ent(32'h1c000000)};
        tbl[5]  = '{1'b0, 1'b1, 32'h1c000008, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ent(32'h1c000004)};
        tbl[6]  = '{1'b0, 1'b1, 32'h1c00000c, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ent(32'h1c000008)};
        tbl[7]  = '{1'b0, 1'b1, 32'h1c000010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ent(32'h1c00000c)};
        // branch cancel with a full queue, then target 1c000100
        tbl[8]  = '{1'b0, 1'b1, 32'h1c000014, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ent(32'h1c00000c)};
        tbl[9]  = '{1'b0, 1'b1, 32'h1c000100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z};
        tbl[10] = '{1'b0, 1'b1, 32'h1c000104, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ent(32'h1c000100)};
        // misaligned fetch locks the stage until flush
        tbl[11] = '{1'b0, 1'b1, 32'h1c000002, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ent(32'h1c000104)};
        tbl[12] = '{1'b0, 1'b1, 32'h1c000006, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ent(32'h1c000104)};
        tbl[13] = '{1'b0, 1'b1, 32'h1c000006, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, ent(32'h1c000002)};
        tbl[14] = '{1'b0, 1'b1, 32'h1c000006, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, z};
        tbl[15] = '{1'b0, 1'b1, 32'h1c000200, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, z};
        tbl[16] = '{1'b0, 1'b1, 32'h1c000200, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z};
        tbl[17] = '{1'b0, 1'b1, 32'h1c000204, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ent(32'h1c000200)};
        // reset with two entries queued
        tbl[18] = '{1'b1, 1'b1, 32'h1c000208, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ent(32'h1c000200)};
        tbl[19] = '{1'b0, 1'b0, 32'h1c000208, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, z};

        reset = 1'b1;
        drive(1'b1, 1'b0, RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, RESET_PC, 32'h0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].rst, tbl[i].v, tbl[i].pc, ~tbl[i].pc,
                  tbl[i].cancel, tbl[i].flsh, tbl[i].allow);
            check($sformatf("row%0d_stall", i), fs_bus_t'(fs_stall), fs_bus_t'(tbl[i].exp_stall));
            check($sformatf("row%0d_valid", i), fs_bus_t'(fs_to_ds_valid), fs_bus_t'(tbl[i].exp_valid));
            check($sformatf("row%0d_bus", i), fs_to_ds_bus, tbl[i].exp_bus);
        end

        // Random traffic; the bench plays pre-IF, advancing pc only when an entry is accepted.
        model_q.delete();
        model_lock = 1'b0;
        pc_cur     = RESET_PC;
        for (int c = 0; c < 600; c++) begin
            rst    = ($urandom % 64) == 0;
            flsh   = ($urandom % 24) == 0;
            cancel = ($urandom % 12) == 0;
            v      = ($urandom % 5) != 0;
            allow  = ($urandom % 3) != 0;
            rdata  = $urandom;

            e_stall = (model_q.size() == QDEPTH) || model_lock;
            e_valid = (model_q.size() != 0) && !(flsh || cancel);
            e_bus   = (model_q.size() != 0) ? model_q[0] : '0;

            drive(rst, v, pc_cur, rdata, cancel, flsh, allow);
            check($sformatf("rnd%0d_stall", c), fs_bus_t'(fs_stall), fs_bus_t'(e_stall));
            check($sformatf("rnd%0d_valid", c), fs_bus_t'(fs_to_ds_valid), fs_bus_t'(e_valid));
            check($sformatf("rnd%0d_bus", c), fs_to_ds_bus, e_bus);

            if (rst) begin
                model_q.delete();
                model_lock = 1'b0;
                pc_cur     = RESET_PC;
            end else if (flsh || cancel) begin
                model_q.delete();
                if (flsh) model_lock = 1'b0;
                pc_cur = {$urandom, 2'b00};
                if (($urandom % 8) == 0) pc_cur[1:0] = 2'($urandom_range(1, 3));
            end else begin
                if (e_valid && allow) void'(model_q.pop_front());
                if (v && !e_stall) begin
                    adef = (pc_cur[1:0] != 2'b00);
                    model_q.push_back({adef, pc_cur, adef ? NOP_INST : rdata});
                    if (adef) model_lock = 1'b1;
                    pc_cur = pc_cur + 32'd4;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
